// File: rtl/alu_share_scheduler.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// per-opcode latency countdown, divide-by-zero bypass and a held response.
module alu_share_scheduler #(
  parameter int unsigned W       = 8,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [3:0]     req0_control,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [3:0]     req1_control,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [3:0]     alu_control,
  input  logic [2*W-1:0] alu_out,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          div_zero;
  logic          txn_id;

  logic          grant0_c;
  logic          grant1_c;
  logic [W-1:0]  sel_a_c;
  logic [W-1:0]  sel_b_c;
  logic [3:0]    sel_ctl_c;
  logic          sel_dz_c;
  logic [CW-1:0] sel_lat_c;

  // Readies are combinational so a valid that drops is never accepted.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant)) grant0_c = 1'b1;
      else if (req1_valid)                           grant1_c = 1'b1;
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  // Winner's operands and the latency its opcode needs.
  always_comb begin
    sel_a_c   = grant1_c ? req1_a       : req0_a;
    sel_b_c   = grant1_c ? req1_b       : req0_b;
    sel_ctl_c = grant1_c ? req1_control : req0_control;
    sel_dz_c  = (sel_ctl_c[3:2] == 2'b11) && (sel_b_c == W'(0));
    sel_lat_c = CW'(1);
    case (sel_ctl_c[3:2])
      2'b10:   sel_lat_c = CW'(MUL_LAT);
      2'b11:   sel_lat_c = sel_dz_c ? CW'(1) : CW'(DIV_LAT);
      default: sel_lat_c = CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cnt         <= '0;
      div_zero    <= 1'b0;
      txn_id      <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c || grant1_c) begin
            alu_a       <= sel_a_c;
            alu_b       <= sel_b_c;
            alu_control <= sel_ctl_c;
            txn_id      <= grant1_c;
            last_grant  <= grant1_c;
            div_zero    <= sel_dz_c;
            cnt         <= sel_lat_c;
            state       <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_data  <= div_zero ? '1 : alu_out;
            rsp_err   <= div_zero;
            rsp_id    <= txn_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
